// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master -- queued command front end driving a single APB3 slave.
//
// Commands are pushed into an in-order FIFO (CMD_DEPTH entries) and replayed
// one at a time as APB SETUP/ACCESS transfers. Reads add one RDWAIT cycle in
// which apb_rdata is captured; the data comes out on rsp_rdata with a
// one-cycle rsp_valid strobe. Writes produce no response.
//
// Widths come from `AWIDTH / `DWIDTH (normally supplied by macros.vh); a
// 32-bit fallback is defined here if the including build has not set them.
//
// Optional feature: define APB_MASTER_STATS_EN to add 16-bit wr_count /
// rd_count transfer counters as extra outputs.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready = FIFO not full)
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rsp_rdata      read response strobe and held read data
//   apb_addr/sel/enable/write/wdata/rdata   APB master-side signals
//   wr_count/rd_count        transfer counters (APB_MASTER_STATS_EN only)
//   busy                     FIFO non-empty or a transfer in progress
// ---------------------------------------------------------------------------
`ifndef AWIDTH
`define AWIDTH 32
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module apb_master #(
    parameter int CMD_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [`AWIDTH-1:0] cmd_addr,
    input  logic [`DWIDTH-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic [`DWIDTH-1:0] rsp_rdata,
    output logic [`AWIDTH-1:0] apb_addr,
    output logic               apb_sel,
    output logic               apb_enable,
    output logic               apb_write,
    output logic [`DWIDTH-1:0] apb_wdata,
    input  logic [`DWIDTH-1:0] apb_rdata,
`ifdef APB_MASTER_STATS_EN
    output logic [15:0]        wr_count,
    output logic [15:0]        rd_count,
`endif
    output logic               busy
);

    localparam int AW = `AWIDTH;
    localparam int DW = `DWIDTH;
    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_t;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    logic          fifo_wr   [CMD_DEPTH];
    logic [AW-1:0] fifo_addr [CMD_DEPTH];
    logic [DW-1:0] fifo_data [CMD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, push, pop;

    assign empty     = (count == '0);
    assign cmd_ready = (count != CMD_DEPTH[PW:0]);
    assign push      = cmd_valid && cmd_ready;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr]   <= cmd_write;
            fifo_addr[wr_ptr] <= cmd_addr;
            fifo_data[wr_ptr] <= cmd_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Transfer FSM
    // -----------------------------------------------------------------------
    state_t state, next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            // apb_write still holds the flag of the transfer now completing.
            ACCESS:  if (!apb_write)  next_state = RDWAIT;
                     else if (!empty) next_state = SETUP;
                     else             next_state = IDLE;
            RDWAIT:  next_state = empty ? IDLE : SETUP;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every APB
    // signal leaves a flop. SETUP is only ever entered by popping the head.
    logic sel_d, en_d, rsp_valid_d;

    always_comb begin
        pop         = (next_state == SETUP);
        sel_d       = (next_state == SETUP) || (next_state == ACCESS);
        en_d        = (next_state == ACCESS);
        rsp_valid_d = (state == RDWAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_sel    <= 1'b0;
            apb_enable <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= '0;
            apb_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            apb_sel    <= sel_d;
            apb_enable <= en_d;
            rsp_valid  <= rsp_valid_d;
            // Address/control only change on a pop, so they are stable from
            // SETUP through ACCESS (and RDWAIT, where apb_rdata is sampled).
            if (pop) begin
                apb_write <= fifo_wr[rd_ptr];
                apb_addr  <= fifo_addr[rd_ptr];
                apb_wdata <= fifo_data[rd_ptr];
            end
            if (state == RDWAIT) rsp_rdata <= apb_rdata;
        end
    end

    assign busy = !empty || (state != IDLE);

`ifdef APB_MASTER_STATS_EN
    // -----------------------------------------------------------------------
    // Transfer counters, free-running and wrapping at 16 bits.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (state == ACCESS && apb_write) wr_count <= wr_count + 16'd1;
            if (rsp_valid)                    rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_apb_master.sv
`ifndef AWIDTH
`define AWIDTH 32
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module tb_apb_master;
    localparam int AW = `AWIDTH;
    localparam int DW = `DWIDTH;
    localparam int CMD_DEPTH = 4;
    localparam int MAXC = 1024;

    logic clk, rst;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] apb_addr;
    logic apb_sel, apb_enable, apb_write;
    logic [DW-1:0] apb_wdata, apb_rdata;
    logic busy;
`ifdef APB_MASTER_STATS_EN
    logic [15:0] wr_count, rd_count;
`endif

    apb_master #(.CMD_DEPTH(CMD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable),
        .apb_write(apb_write), .apb_wdata(apb_wdata), .apb_rdata(apb_rdata),
`ifdef APB_MASTER_STATS_EN
        .wr_count(wr_count), .rd_count(rd_count),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait-state APB slave: 16-word memory, reads combinational.
    logic [DW-1:0] smem [16];
    assign apb_rdata = smem[apb_addr[5:2]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) smem[i] <= '0;
        end else if (apb_sel && apb_enable && apb_write) begin
            smem[apb_addr[5:2]] <= apb_wdata;
        end
    end

    // Reference timeline: every accepted command k gets its SETUP cycle from
    // its accept cycle and the end of the previous command; the expected
    // outputs of any cycle follow from that schedule.
    int            acc_c [MAXC];
    int            setup_c [MAXC];
    int            end_c [MAXC];
    bit            m_wr [MAXC];
    logic [AW-1:0] m_addr [MAXC];
    logic [DW-1:0] m_data [MAXC];
    logic [DW-1:0] m_rd [MAXC];
    logic [DW-1:0] mmem [16];
    logic [DW-1:0] rsp_hold;
    int  n, base, cyc;
    bit  exp_ready, exp_busy, last_acc;
    int  total, fails;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        base = n;
        rsp_hold = '0;
        for (int i = 0; i < 16; i++) mmem[i] = '0;
    endtask

    task automatic schedule(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k, prev_end;
        k = n;
        prev_end = (n > base) ? end_c[n-1] : -100;
        acc_c[k]   = cyc;
        setup_c[k] = (cyc + 2 > prev_end + 1) ? cyc + 2 : prev_end + 1;
        end_c[k]   = setup_c[k] + (w ? 1 : 2);
        m_wr[k] = w; m_addr[k] = a; m_data[k] = d;
        if (w) mmem[a[5:2]] = d;
        else   m_rd[k] = mmem[a[5:2]];
        n++;
    endtask

    task automatic check_cycle();
        int occ;
        bit s, e, act, rv, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
`ifdef APB_MASTER_STATS_EN
        logic [15:0] wc, rc;
        wc = '0; rc = '0;
`endif
        occ = 0; s = 0; e = 0; act = 0; rv = 0; ew = 0; ea = '0; ed = '0;
        for (int k = base; k < n; k++) begin
            if (acc_c[k] < cyc)    occ++;
            if (setup_c[k] <= cyc) occ--;
            if (cyc >= setup_c[k] && cyc <= end_c[k]) begin
                act = 1;
                s  = (cyc <= setup_c[k] + 1);
                e  = (cyc == setup_c[k] + 1);
                ea = m_addr[k]; ew = m_wr[k]; ed = m_data[k];
            end
            if (!m_wr[k] && end_c[k] + 1 == cyc) begin
                rv = 1;
                rsp_hold = m_rd[k];
            end
`ifdef APB_MASTER_STATS_EN
            if (m_wr[k] && end_c[k] < cyc)       wc++;
            if (!m_wr[k] && end_c[k] + 2 <= cyc) rc++;
`endif
        end
        exp_ready = (occ < CMD_DEPTH);
        exp_busy  = (occ > 0) || act;
        chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("apb_sel", 64'(apb_sel), 64'(s));
        chk("apb_enable", 64'(apb_enable), 64'(e));
        chk("rsp_valid", 64'(rsp_valid), 64'(rv));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(rsp_hold));
        if (s) begin
            chk("apb_addr", 64'(apb_addr), 64'(ea));
            chk("apb_write", 64'(apb_write), 64'(ew));
            if (ew) chk("apb_wdata", 64'(apb_wdata), 64'(ed));
        end
`ifdef APB_MASTER_STATS_EN
        chk("wr_count", 64'(wr_count), 64'(wc));
        chk("rd_count", 64'(rd_count), 64'(rc));
`endif
    endtask

    // One clock cycle: check mid-cycle, then offer (or not) a command.
    task automatic step(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cyc++;
        check_cycle();
        cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        last_acc = v && exp_ready;
        if (last_acc) begin
            if (n >= MAXC) begin
                $display("FAIL model_capacity: got %0d commands, limit %0d", n, MAXC);
                $fatal(1);
            end
            schedule(w, a, d);
        end
    endtask

    // Offer one command and hold it until accepted (bounded).
    task automatic push_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int tries;
        tries = 0;
        do begin
            step(1'b1, w, a, d);
            tries++;
        end while (!last_acc && tries < 50);
        if (!last_acc) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            step(1'b0, 1'b0, '0, '0);
            t++;
        end while ((exp_busy || t < 3) && t < 200);
        if (exp_busy) chk("drain_timeout", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel"},    64'(apb_sel), 64'(0));
        chk({tag, "_enable"}, 64'(apb_enable), 64'(0));
        chk({tag, "_write"},  64'(apb_write), 64'(0));
        chk({tag, "_addr"},   64'(apb_addr), 64'(0));
        chk({tag, "_wdata"},  64'(apb_wdata), 64'(0));
        chk({tag, "_rvalid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rdata"},  64'(rsp_rdata), 64'(0));
        chk({tag, "_busy"},   64'(busy), 64'(0));
        chk({tag, "_ready"},  64'(cmd_ready), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pend, pw;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        total = 0; fails = 0; n = 0; base = 0; cyc = 0;
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        model_reset();

        // Power-on reset.
        repeat (3) begin
            @(negedge clk); cyc++;
            check_reset_outputs("reset");
        end
        rst = 1'b0;
        idle(2);

        // Single write: SETUP two cycles after handshake, ACCESS after that.
        push_cmd(1'b1, 32'h10, 32'hA5A5_A5A5);
        drain();

        // Write then read back the same address.
        push_cmd(1'b1, 32'h10, 32'h0000_1234);
        drain();
        push_cmd(1'b0, 32'h10, '0);
        drain();

        // Read keeps the FSM busy while writes stream in with valid held:
        // the FIFO fills, stalls, then drains back-to-back.
        push_cmd(1'b0, 32'h10, '0);
        for (int i = 0; i < 6; i++)
            push_cmd(1'b1, AW'((i + 1) * 4), DW'($urandom));
        drain();

        // Randomized traffic with idle gaps.
        pend = 0; pw = 0; pa = '0; pd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend && ($urandom_range(0, 9) < 6)) begin
                pend = 1;
                pw = $urandom_range(0, 1);
                pa = AW'($urandom_range(0, 15) * 4);
                pd = DW'($urandom);
            end
            step(pend, pw, pa, pd);
            if (last_acc) pend = 0;
        end
        drain();

        // Reset during the ACCESS of a read with two writes queued.
        push_cmd(1'b0, 32'h08, '0);
        push_cmd(1'b1, 32'h0C, 32'hDEAD_BEEF);
        push_cmd(1'b1, 32'h14, 32'hCAFE_F00D);
        step(1'b0, 1'b0, '0, '0);           // read ACCESS cycle
        chk("pre_reset_access", 64'({apb_sel, apb_enable, apb_write}), 64'(3'b110));
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_abort");
        model_reset();
        repeat (3) begin
            @(negedge clk); cyc++;
            check_reset_outputs("abort_hold");
        end
        rst = 1'b0;
        idle(2);
        drain();

        // Post-reset reads see only zeros.
        push_cmd(1'b0, AW'($urandom_range(0, 15) * 4), '0);
        push_cmd(1'b0, 32'h0C, '0);
        drain();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
